button_event_scheduler: RTL

Collects debounced button levels from the per-button `debounce` instances and turns them into discrete PRESS, REPEAT (auto-repeat while held) and RELEASE events. Events are queued per button and shared onto a single event channel by a round-robin arbiter with a valid/ready handshake. The block sits between the debounced inputs and the game/control FSM, which consumes one event at a time.

---
 rtl/btn_pkg.sv | 30 +++
 rtl/btn_event_tracker.sv | 98 +++++++++
 rtl/button_event_scheduler.sv | 108 ++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared event-kind codes, pending-bit positions and per-button state encoding
// for the button event scheduler.
package btn_pkg;

   localparam logic [1:0] EV_PRESS   = 2'd0;
   localparam logic [1:0] EV_REPEAT  = 2'd1;
   localparam logic [1:0] EV_RELEASE = 2'd2;

   // Pending bit index equals the event-kind code it produces.
   localparam int PEND_P = 0;
   localparam int PEND_R = 1;
   localparam int PEND_L = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_RPT  = 2'd2
   } btn_state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [1:0] pick_kind(input logic [2:0] pend);
      if (pend[PEND_P])      return EV_PRESS;
      else if (pend[PEND_R]) return EV_REPEAT;
      else                   return EV_RELEASE;
   endfunction

endpackage

// File: rtl/btn_event_tracker.sv
// Per-button edge detect, hold/repeat timer and PRESS/REPEAT/RELEASE pending bits.
// Pending bit is set on the edge that sees the event; take_i clears it; drop_o flags a lost event.
module btn_event_tracker
   import btn_pkg::*;
#(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 12_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       level_i,
   input  logic [2:0] take_i,
   output logic [2:0] pend_o,
   output logic       drop_o
);

   localparam int CW = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES));
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);

   btn_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic          prev_q;
   logic [2:0]    pend_q;
   logic [2:0]    pend_d;
   logic [2:0]    set_ev;
   logic          rise;
   logic          fall;

   always_comb begin
      rise   = level_i & ~prev_q;
      fall   = ~level_i & prev_q;
      set_ev = 3'b000;
      // A release wins over a coincident threshold, so no REPEAT follows the fall.
      case (state_q)
         ST_IDLE: set_ev[PEND_P] = rise;
         ST_HELD: begin
            set_ev[PEND_L] = fall;
            set_ev[PEND_R] = ~fall && (cnt_q == HOLD_LAST);
         end
         ST_RPT: begin
            set_ev[PEND_L] = fall;
            set_ev[PEND_R] = ~fall && (cnt_q == RPT_LAST);
         end
         default: set_ev = 3'b000;
      endcase
      pend_d = set_ev | (pend_q & ~take_i);
      drop_o = |(set_ev & pend_q & ~take_i);
   end

   assign pend_o = pend_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         prev_q  <= 1'b0;
         pend_q  <= 3'b000;
      end else begin
         prev_q <= level_i;
         pend_q <= pend_d;
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  cnt_q   <= '0;
                  state_q <= ST_HELD;
               end
            end
            ST_HELD: begin
               if (fall) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else if (cnt_q == HOLD_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_RPT;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_RPT: begin
               if (fall) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else if (cnt_q == RPT_LAST) begin
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_event_scheduler.sv
// Round-robin merge of per-button PRESS/REPEAT/RELEASE events onto one valid/ready channel.
// Two cycles from a sampled rise to ev_valid; ev_id/ev_kind hold while ev_ready is low.
module button_event_scheduler
   import btn_pkg::*;
#(
   parameter int N_BTN         = 4,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 12_500_000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_BTN-1:0]           btn_level,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [$clog2(N_BTN)-1:0]   ev_id,
   output logic [1:0]                 ev_kind,
   output logic                       overflow,
   input  logic                       ovf_clr
);

   localparam int IW = $clog2(N_BTN);

   logic [2:0]       pend [N_BTN];
   logic [2:0]       take [N_BTN];
   logic [N_BTN-1:0] drop;

   logic          valid_q;
   logic [IW-1:0] id_q;
   logic [1:0]    kind_q;
   logic          ovf_q;
   logic [IW-1:0] rr_q;
   logic [IW-1:0] rr_d;

   logic          any_elig;
   logic [IW-1:0] gnt_id;
   logic [1:0]    gnt_kind;
   logic          load;
   int            idx;
   logic [IW-1:0] idx_w;

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      btn_event_tracker #(
         .HOLD_CYCLES  (HOLD_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_trk (
         .clk    (clk),
         .rst_n  (rst_n),
         .level_i(btn_level[g]),
         .take_i (take[g]),
         .pend_o (pend[g]),
         .drop_o (drop[g])
      );
   end

   // First eligible button at or after rr_q, wrapping.
   always_comb begin
      any_elig = 1'b0;
      gnt_id   = '0;
      gnt_kind = EV_PRESS;
      idx      = 0;
      idx_w    = '0;
      for (int k = 0; k < N_BTN; k++) begin
         idx   = (int'(rr_q) + k) % N_BTN;
         idx_w = IW'(idx);
         if (!any_elig && (|pend[idx_w])) begin
            any_elig = 1'b1;
            gnt_id   = idx_w;
            gnt_kind = pick_kind(pend[idx_w]);
         end
      end
   end

   assign load = any_elig && (!valid_q || ev_ready);
   assign rr_d = (gnt_id == IW'(N_BTN - 1)) ? '0 : gnt_id + IW'(1);

   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         take[i] = (load && (gnt_id == IW'(i))) ? (3'b001 << gnt_kind) : 3'b000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         kind_q  <= EV_PRESS;
         ovf_q   <= 1'b0;
         rr_q    <= '0;
      end else begin
         if (load) begin
            valid_q <= 1'b1;
            id_q    <= gnt_id;
            kind_q  <= gnt_kind;
            rr_q    <= rr_d;
         end else if (ev_ready) begin
            valid_q <= 1'b0;
         end
         if (|drop)        ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   assign ev_valid = valid_q;
   assign ev_id    = id_q;
   assign ev_kind  = kind_q;
   assign overflow = ovf_q;

endmodule
